// File: rtl/ysyx_22041211_inst_sequencer_if.sv
// Bus bundle between the instruction sequencer and its surroundings:
// the fetch port, the data-memory port, the decoder's control fields and
// the regfile/CSR write strobes.
//
// Handshake rule for both memory ports: the sequencer raises *_req_o and
// holds it, with its address/direction stable, until the responder drives
// *_valid_i high for one cycle. The transfer completes on the clock edge
// where req and valid are both high. A valid seen while req is low is
// ignored.
interface ysyx_22041211_inst_sequencer_if;
  // instruction fetch port
  logic        ifu_req_o;
  logic        ifu_valid_i;
  logic [31:0] ifu_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  // decoder control fields
  logic        dec_wd_i;
  logic [1:0]  dec_store_type_i;
  logic [2:0]  dec_load_type_i;
  logic [2:0]  dec_branch_type_i;
  logic [31:0] dec_branch_tgt_i;
  logic        dec_jmp_flag_i;
  logic [31:0] dec_jmp_tgt_i;
  logic [1:0]  dec_csr_flag_i;
  logic        br_taken_i;

  // data memory port
  logic        lsu_req_o;
  logic        lsu_we_o;
  logic        lsu_valid_i;

  // write strobes and status
  logic        rf_we_o;
  logic        csr_we_o;
  logic        inst_done_o;
  logic        err_o;
  logic [2:0]  dbg_state_o;

  // sequencer side
  modport master (
    output ifu_req_o, pc_o, inst_o, lsu_req_o, lsu_we_o,
           rf_we_o, csr_we_o, inst_done_o, err_o, dbg_state_o,
    input  ifu_valid_i, ifu_rdata_i, lsu_valid_i,
           dec_wd_i, dec_store_type_i, dec_load_type_i, dec_branch_type_i,
           dec_branch_tgt_i, dec_jmp_flag_i, dec_jmp_tgt_i, dec_csr_flag_i,
           br_taken_i
  );

  // memory / decoder side
  modport slave (
    input  ifu_req_o, pc_o, inst_o, lsu_req_o, lsu_we_o,
           rf_we_o, csr_we_o, inst_done_o, err_o, dbg_state_o,
    output ifu_valid_i, ifu_rdata_i, lsu_valid_i,
           dec_wd_i, dec_store_type_i, dec_load_type_i, dec_branch_type_i,
           dec_branch_tgt_i, dec_jmp_flag_i, dec_jmp_tgt_i, dec_csr_flag_i,
           br_taken_i
  );
endinterface

// File: rtl/ysyx_22041211_inst_sequencer.sv
// Multi-cycle control FSM of the NPC core. Owns the PC and the instruction
// register and walks every instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB, with a bounded wait on each
// memory handshake. A memory port that never answers parks the core in a
// sticky ERR state that only reset leaves.
module ysyx_22041211_inst_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  // "not this kind of instruction" codes used by the decoder
  parameter logic [1:0]  STORE_INVALID  = 2'd0,
  parameter logic [2:0]  LOAD_INVALID   = 3'd0,
  parameter logic [2:0]  BRANCH_INVALID = 3'd0,
  parameter logic [1:0]  CSR_INVALID    = 2'd0
) (
  input logic clk,
  input logic rst_n,
  ysyx_22041211_inst_sequencer_if.master bus
);

  // Wide enough to hold TIMEOUT_CYCLES itself.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // decoded instruction class, only meaningful from EXEC through WB
  logic        is_store;
  logic        is_load;
  logic        is_mem;
  logic        br_hit;
  logic [31:0] next_pc;

  assign is_store = (bus.dec_store_type_i != STORE_INVALID);
  assign is_load  = (bus.dec_load_type_i  != LOAD_INVALID);
  assign is_mem   = is_store | is_load;
  assign br_hit   = (bus.dec_branch_type_i != BRANCH_INVALID) & bus.br_taken_i;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Jumps win over branches; jump targets get bit 0 cleared (jalr rule).
  // The +4 wraps naturally in 32 bits.
  assign next_pc = bus.dec_jmp_flag_i ? (bus.dec_jmp_tgt_i & 32'hFFFF_FFFE) :
                   br_hit             ? bus.dec_branch_tgt_i :
                                        pc_q + 32'd4;

  // State, PC, instruction register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and the per-state output strobes.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    cnt_d           = cnt_q;
    bus.ifu_req_o   = 1'b0;
    bus.lsu_req_o   = 1'b0;
    bus.lsu_we_o    = 1'b0;
    bus.rf_we_o     = 1'b0;
    bus.csr_we_o    = 1'b0;
    bus.inst_done_o = 1'b0;
    bus.err_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        cnt_d   = '0;
      end

      FETCH: begin
        bus.ifu_req_o = 1'b1;
        // A response on the last allowed cycle still counts.
        if (bus.ifu_valid_i) begin
          inst_d  = bus.ifu_rdata_i;
          state_d = DECODE;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // Give the decoder and regfile a cycle to settle from inst_o.
      DECODE: begin
        state_d = EXEC;
      end

      EXEC: begin
        if (is_mem) begin
          state_d = MEM;
          cnt_d   = '0;
        end else begin
          state_d = WB;
        end
      end

      MEM: begin
        bus.lsu_req_o = 1'b1;
        bus.lsu_we_o  = is_store;
        if (bus.lsu_valid_i) begin
          state_d = WB;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WB: begin
        bus.rf_we_o     = bus.dec_wd_i & ~is_store;
        bus.csr_we_o    = (bus.dec_csr_flag_i != CSR_INVALID);
        bus.inst_done_o = 1'b1;
        pc_d            = next_pc;
        cnt_d           = '0;
        state_d         = FETCH;
      end

      ERR: begin
        bus.err_o = 1'b1;
      end

      default: begin
        state_d = ERR;
      end
    endcase
  end

  assign bus.pc_o        = pc_q;
  assign bus.inst_o      = inst_q;
  assign bus.dbg_state_o = state_q;

endmodule
